// File: rtl/mouse_select_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mouse_select_ctrl_pkg
// Shared definitions for the mouse selection controller:
//   - sel_state_e : controller state encoding (IDLE=0, SELECTED=1, ISSUE=2)
//   - GRID_W/GRID_H : playable grid size in blocks
//   - NO_BLOCK_Y : row code the mouse interface reports when no block is hit
//   - in_grid() : true when a block coordinate lies on the playable grid
// -----------------------------------------------------------------------------
package mouse_select_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECTED = 2'd1,
    ST_ISSUE    = 2'd2
  } sel_state_e;

  localparam logic [4:0] GRID_W     = 5'd18;
  localparam logic [3:0] GRID_H     = 4'd8;
  localparam logic [3:0] NO_BLOCK_Y = 4'd8;

  // Row is zero-extended so the compare against GRID_H is done at 4 bits.
  function automatic logic in_grid(input logic [4:0] x, input logic [2:0] y);
    return (x < GRID_W) && ({1'b0, y} < GRID_H);
  endfunction

endpackage

// File: rtl/mouse_select_ctrl_if.sv
// -----------------------------------------------------------------------------
// mouse_select_ctrl_if
// Bundles the mouse inputs, the move handshake and the selection outputs of
// mouse_select_ctrl.
//   master : drives the mouse/turn/ready inputs, observes the outputs
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface mouse_select_ctrl_if;

  logic       l_click;
  logic       mouse_inblock;
  logic [4:0] mouse_block_x;
  logic [2:0] mouse_block_y;
  logic       my_turn;
  logic       move_ready;

  logic       sel_valid;
  logic [4:0] sel_x;
  logic [2:0] sel_y;
  logic       move_valid;
  logic [4:0] src_x;
  logic [2:0] src_y;
  logic [4:0] dst_x;
  logic [2:0] dst_y;
  logic       cancel_pulse;

  modport master (
    output l_click, mouse_inblock, mouse_block_x, mouse_block_y, my_turn, move_ready,
    input  sel_valid, sel_x, sel_y, move_valid, src_x, src_y, dst_x, dst_y, cancel_pulse
  );

  modport slave (
    input  l_click, mouse_inblock, mouse_block_x, mouse_block_y, my_turn, move_ready,
    output sel_valid, sel_x, sel_y, move_valid, src_x, src_y, dst_x, dst_y, cancel_pulse
  );

endinterface

// File: rtl/mouse_select_ctrl_select_timeout_cnt.sv
// -----------------------------------------------------------------------------
// select_timeout_cnt
// Saturating idle counter for an open selection.
//   clk : system clock
//   clr : synchronous clear (has priority over en)
//   en  : count one idle cycle
//   hit : counter sits at TIMEOUT-1
// The counter stops at TIMEOUT-1, so a missed clear can never wrap it back
// into a fresh timeout window.
// -----------------------------------------------------------------------------
module select_timeout_cnt #(
  parameter int unsigned TIMEOUT = 500_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned   CW   = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 32'd1);

  logic [CW-1:0] cnt_r;

  // Idle counter: clear, saturating increment, otherwise hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign hit = (cnt_r == LAST);

endmodule

// File: rtl/mouse_select_ctrl.sv
// -----------------------------------------------------------------------------
// mouse_select_ctrl
// Turns pairs of valid left clicks into tile move requests.
//   clk            : system clock
//   rst            : local reset, synchronous active-high
//   interboard_rst : reset from the peer board, ORed with rst
//   bus (slave)    : mouse inputs, my_turn, move handshake, selection outputs
// First click selects a source block (sel_*), second click on another block
// issues src/dst on a valid/ready handshake. Dropped selections (turn lost,
// click off the grid, re-click on the source, idle timeout) emit one
// cancel_pulse. All outputs are registered.
// -----------------------------------------------------------------------------
module mouse_select_ctrl
  import mouse_select_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 500_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             interboard_rst,
  mouse_select_ctrl_if.slave bus
);

  sel_state_e state_r, state_s;
  logic       sel_valid_r, sel_valid_s;
  logic [4:0] sel_x_r, sel_x_s;
  logic [2:0] sel_y_r, sel_y_s;
  logic       move_valid_r, move_valid_s;
  logic [4:0] src_x_r, src_x_s, dst_x_r, dst_x_s;
  logic [2:0] src_y_r, src_y_s, dst_y_r, dst_y_s;
  logic       cancel_r, cancel_s;

  logic all_rst_s, vclick_s, same_blk_s, hit_s, cnt_clr_s, cnt_en_s;

  assign all_rst_s  = rst | interboard_rst;
  assign vclick_s   = bus.l_click & bus.mouse_inblock & bus.my_turn &
                      in_grid(bus.mouse_block_x, bus.mouse_block_y);
  assign same_blk_s = (bus.mouse_block_x == sel_x_r) && (bus.mouse_block_y == sel_y_r);

  select_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk (clk),
    .clr (all_rst_s | cnt_clr_s),
    .en  (cnt_en_s),
    .hit (hit_s)
  );

  // Next-state and next-output logic; everything holds unless a rule fires.
  always_comb begin
    state_s      = state_r;
    sel_valid_s  = sel_valid_r;
    sel_x_s      = sel_x_r;
    sel_y_s      = sel_y_r;
    move_valid_s = move_valid_r;
    src_x_s      = src_x_r;
    src_y_s      = src_y_r;
    dst_x_s      = dst_x_r;
    dst_y_s      = dst_y_r;
    cancel_s     = 1'b0;
    cnt_clr_s    = 1'b0;
    cnt_en_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (vclick_s) begin
          sel_x_s     = bus.mouse_block_x;
          sel_y_s     = bus.mouse_block_y;
          sel_valid_s = 1'b1;
          cnt_clr_s   = 1'b1;
          state_s     = ST_SELECTED;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SELECTED: begin
        // Turn loss beats any click; a click beats the timeout.
        if (!bus.my_turn || (bus.l_click && !bus.mouse_inblock) || (vclick_s && same_blk_s)) begin
          sel_valid_s = 1'b0;
          cancel_s    = 1'b1;
          state_s     = ST_IDLE;
        end else if (vclick_s) begin
          src_x_s      = sel_x_r;
          src_y_s      = sel_y_r;
          dst_x_s      = bus.mouse_block_x;
          dst_y_s      = bus.mouse_block_y;
          move_valid_s = 1'b1;
          state_s      = ST_ISSUE;
        end else if (hit_s) begin
          sel_valid_s = 1'b0;
          cancel_s    = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          cnt_en_s = 1'b1;
          state_s  = ST_SELECTED;
        end
      end
      ST_ISSUE: begin
        // Clicks and turn changes are ignored until the move is taken.
        if (move_valid_r && bus.move_ready) begin
          move_valid_s = 1'b0;
          sel_valid_s  = 1'b0;
          state_s      = ST_IDLE;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      default: begin
        sel_valid_s  = 1'b0;
        move_valid_s = 1'b0;
        state_s      = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides any pending handshake.
  always_ff @(posedge clk) begin
    if (all_rst_s) begin
      state_r      <= ST_IDLE;
      sel_valid_r  <= 1'b0;
      sel_x_r      <= 5'd0;
      sel_y_r      <= 3'd0;
      move_valid_r <= 1'b0;
      src_x_r      <= 5'd0;
      src_y_r      <= 3'd0;
      dst_x_r      <= 5'd0;
      dst_y_r      <= 3'd0;
      cancel_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      sel_valid_r  <= sel_valid_s;
      sel_x_r      <= sel_x_s;
      sel_y_r      <= sel_y_s;
      move_valid_r <= move_valid_s;
      src_x_r      <= src_x_s;
      src_y_r      <= src_y_s;
      dst_x_r      <= dst_x_s;
      dst_y_r      <= dst_y_s;
      cancel_r     <= cancel_s;
    end
  end

  assign bus.sel_valid    = sel_valid_r;
  assign bus.sel_x        = sel_x_r;
  assign bus.sel_y        = sel_y_r;
  assign bus.move_valid   = move_valid_r;
  assign bus.src_x        = src_x_r;
  assign bus.src_y        = src_y_r;
  assign bus.dst_x        = dst_x_r;
  assign bus.dst_y        = dst_y_r;
  assign bus.cancel_pulse = cancel_r;

endmodule

// File: tb/tb_mouse_select_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mouse_select_ctrl
// Directed scenarios with constant expectations plus a randomized run checked
// against a click-level reference model. TIMEOUT is shortened to 16 cycles.
// The 3-bit row port cannot carry row code 8, so a "no block" report from the
// mouse interface is driven as mouse_inblock=0 with the truncated row code.
// -----------------------------------------------------------------------------
module tb_mouse_select_ctrl;
  import mouse_select_ctrl_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic interboard_rst = 1'b0;

  mouse_select_ctrl_if bus ();

  mouse_select_ctrl #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: an open selection, a pending move, and the idle age.
  bit m_sel = 1'b0, m_mv = 1'b0, m_cancel = 1'b0;
  int m_sx = 0, m_sy = 0, m_srcx = 0, m_srcy = 0, m_dstx = 0, m_dsty = 0, m_age = 0;

  always @(posedge clk) begin : ref_model
    bit v;
    v = bus.l_click && bus.mouse_inblock && bus.my_turn &&
        (int'(bus.mouse_block_x) < 18) && (int'(bus.mouse_block_y) < 8);
    m_cancel = 1'b0;
    if (rst || interboard_rst) begin
      m_sel = 1'b0; m_mv = 1'b0; m_age = 0;
      m_sx = 0; m_sy = 0; m_srcx = 0; m_srcy = 0; m_dstx = 0; m_dsty = 0;
    end else if (m_mv) begin
      if (bus.move_ready) begin m_mv = 1'b0; m_sel = 1'b0; end
    end else if (m_sel) begin
      if (!bus.my_turn || (bus.l_click && !bus.mouse_inblock) ||
          (v && int'(bus.mouse_block_x) == m_sx && int'(bus.mouse_block_y) == m_sy)) begin
        m_sel = 1'b0; m_cancel = 1'b1;
      end else if (v) begin
        m_srcx = m_sx; m_srcy = m_sy;
        m_dstx = bus.mouse_block_x; m_dsty = bus.mouse_block_y;
        m_mv = 1'b1;
      end else if (m_age == TO - 1) begin
        m_sel = 1'b0; m_cancel = 1'b1;
      end else begin
        m_age++;
      end
    end else if (v) begin
      m_sel = 1'b1; m_sx = bus.mouse_block_x; m_sy = bus.mouse_block_y; m_age = 0;
    end
  end

  function automatic logic [26:0] pack(bit sv, int sx, int sy, bit mv, int srx, int sry,
                                       int dsx, int dsy, bit c);
    return {sv, 5'(sx), 3'(sy), mv, 5'(srx), 3'(sry), 5'(dsx), 3'(dsy), c};
  endfunction

  function automatic logic [26:0] obs();
    return {bus.sel_valid, bus.sel_x, bus.sel_y, bus.move_valid, bus.src_x, bus.src_y,
            bus.dst_x, bus.dst_y, bus.cancel_pulse};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic click(int x, int y, bit inb);
    bus.l_click       = 1'b1;
    bus.mouse_inblock = inb;
    bus.mouse_block_x = 5'(x);
    bus.mouse_block_y = 3'(y);
    tick();
    bus.l_click = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [26:0] e;
    rst = 1'b0;
    click(4, 4, 1'b1);
    // Reset together with a valid click: reset must win.
    rst = 1'b1;
    bus.l_click = 1'b1;
    tick();
    bus.l_click = 1'b0;
    rst = 1'b0;
    e = pack(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL reset_state got %h exp %h", obs(), e); end
  endtask

  task automatic test_move();
    logic [26:0] e;
    do_reset();
    click(3, 2, 1'b1);
    e = pack(1, 3, 2, 0, 0, 0, 0, 0, 0);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL move_first_click got %h exp %h", obs(), e); end
    click(10, 6, 1'b1);
    e = pack(1, 3, 2, 1, 3, 2, 10, 6, 0);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL move_issue got %h exp %h", obs(), e); end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL move_hold[%0d] got %h exp %h", i, obs(), e); end
    end
    bus.move_ready = 1'b1;
    tick();
    bus.move_ready = 1'b0;
    e = pack(0, 3, 2, 0, 3, 2, 10, 6, 0);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL move_accept got %h exp %h", obs(), e); end
  endtask

  task automatic test_cancel_same();
    logic [26:0] e;
    do_reset();
    click(5, 1, 1'b1);
    e = pack(1, 5, 1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL same_select got %h exp %h", obs(), e); end
    click(5, 1, 1'b1);
    e = pack(0, 5, 1, 0, 0, 0, 0, 0, 1);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL same_cancel got %h exp %h", obs(), e); end
    tick();
    e = pack(0, 5, 1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL same_pulse_end got %h exp %h", obs(), e); end
  endtask

  task automatic test_outside();
    logic [26:0] e;
    int nb;
    nb = int'(NO_BLOCK_Y);
    do_reset();
    click(0, 0, 1'b1);
    click(9, 3, 1'b0);
    e = pack(0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL out_inblock_cancel got %h exp %h", obs(), e); end
    click(0, nb, 1'b0);
    e = pack(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL out_noblock_idle got %h exp %h", obs(), e); end
    click(20, 3, 1'b1);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL out_xrange_idle got %h exp %h", obs(), e); end
    click(17, 7, 1'b1);
    e = pack(1, 17, 7, 0, 0, 0, 0, 0, 0);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL out_corner_select got %h exp %h", obs(), e); end
    click(4, nb, 1'b0);
    e = pack(0, 17, 7, 0, 0, 0, 0, 0, 1);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL out_noblock_cancel got %h exp %h", obs(), e); end
  endtask

  task automatic test_timeout();
    logic [26:0] e;
    do_reset();
    click(7, 7, 1'b1);
    e = pack(1, 7, 7, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < TO; i++) begin
      tick();
      n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL timeout_wait[%0d] got %h exp %h", i, obs(), e); end
    end
    tick();
    e = pack(0, 7, 7, 0, 0, 0, 0, 0, 1);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL timeout_cancel got %h exp %h", obs(), e); end
  endtask

  task automatic test_simultaneous();
    logic [26:0] e;
    do_reset();
    click(7, 3, 1'b1);
    bus.my_turn = 1'b0;
    click(2, 4, 1'b1);
    bus.my_turn = 1'b1;
    e = pack(0, 7, 3, 0, 0, 0, 0, 0, 1);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL simul_turn_wins got %h exp %h", obs(), e); end
    click(1, 1, 1'b1);
    click(4, 5, 1'b1);
    e = pack(1, 1, 1, 1, 1, 1, 4, 5, 0);
    bus.my_turn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      click(1, 1, (i % 2) == 0);
      n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL simul_issue_hold[%0d] got %h exp %h", i, obs(), e); end
    end
    bus.move_ready = 1'b1;
    tick();
    bus.move_ready = 1'b0;
    bus.my_turn = 1'b1;
    e = pack(0, 1, 1, 0, 1, 1, 4, 5, 0);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL simul_accept got %h exp %h", obs(), e); end
  endtask

  task automatic test_interboard_rst();
    logic [26:0] e;
    do_reset();
    click(3, 3, 1'b1);
    click(6, 2, 1'b1);
    e = pack(1, 3, 3, 1, 3, 3, 6, 2, 0);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL ibrst_issue got %h exp %h", obs(), e); end
    interboard_rst = 1'b1;
    tick();
    interboard_rst = 1'b0;
    e = pack(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL ibrst_clear got %h exp %h", obs(), e); end
    tick();
    n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL ibrst_no_cancel got %h exp %h", obs(), e); end
  endtask

  task automatic test_random();
    logic [26:0] e;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.l_click       = ($urandom_range(0, 3) == 0);
      bus.mouse_inblock = ($urandom_range(0, 7) != 0);
      bus.mouse_block_x = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 2));
      bus.mouse_block_y = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      bus.my_turn       = ($urandom_range(0, 15) != 0);
      bus.move_ready    = ($urandom_range(0, 3) == 0);
      rst               = ($urandom_range(0, 299) == 0);
      interboard_rst    = ($urandom_range(0, 299) == 0);
      tick();
      e = pack(m_sel, m_sx, m_sy, m_mv, m_srcx, m_srcy, m_dstx, m_dsty, m_cancel);
      n_chk++; if (obs() !== e) begin n_fail++; $display("FAIL random[%0d] got %h exp %h", i, obs(), e); end
    end
    rst = 1'b0;
    interboard_rst = 1'b0;
    bus.l_click = 1'b0;
  endtask

  initial begin
    bus.l_click       = 1'b0;
    bus.mouse_inblock = 1'b0;
    bus.mouse_block_x = 5'd0;
    bus.mouse_block_y = 3'd0;
    bus.my_turn       = 1'b1;
    bus.move_ready    = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    test_move();
    test_cancel_same();
    test_outside();
    test_timeout();
    test_simultaneous();
    test_interboard_rst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
